// File: rtl/store_queue.sv
// Circular in-order store queue: dispatch allocation, execute fill, retire commit,
// cache drain over valid/ready, and byte-granular store-to-load forwarding.
module store_queue #(
  parameter int unsigned SQ_SZ = 8,
  parameter int unsigned IDXW  = $clog2(SQ_SZ),
  parameter int unsigned PW    = IDXW + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            disp_valid,
  output logic            sq_full,
  output logic            sq_empty,
  output logic [PW-1:0]   sq_tail,
  input  logic            exec_valid,
  input  logic [IDXW-1:0] exec_idx,
  input  logic [31:0]     exec_addr,
  input  logic [31:0]     exec_data,
  input  logic [1:0]      exec_size,
  input  logic            retire_valid,
  input  logic            mispred,
  input  logic [PW-1:0]   rollback_tail,
  input  logic [31:0]     load_req_addr,
  input  logic [PW-1:0]   load_sq_tail,
  output logic [31:0]     sq_load_data,
  output logic [3:0]      sq_data_mask,
  output logic            sq_addr_unknown,
  output logic            st_req_valid,
  output logic [31:0]     st_req_addr,
  output logic [31:0]     st_req_data,
  output logic [3:0]      st_req_mask,
  input  logic            st_req_ready
);

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_ALLOC  = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  logic [1:0]      state_q [SQ_SZ];
  logic [1:0]      state_d [SQ_SZ];
  logic [29:0]     addr_q  [SQ_SZ];
  logic [31:0]     data_q  [SQ_SZ];
  logic [3:0]      mask_q  [SQ_SZ];

  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   commit_q, commit_d;
  logic [PW-1:0]   tail_q, tail_d;

  logic [IDXW-1:0] head_idx, commit_idx, tail_idx;
  logic            disp_fire, exec_fire, retire_fire, drain_fire;
  logic [3:0]      exec_mask;
  logic [31:0]     exec_shift, exec_lane_data;
  logic [PW-1:0]   squash_cnt;
  logic [PW-1:0]   fwd_span;
  logic [IDXW-1:0] fwd_idx;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ^load_req_addr[1:0];

  assign head_idx   = head_q[IDXW-1:0];
  assign commit_idx = commit_q[IDXW-1:0];
  assign tail_idx   = tail_q[IDXW-1:0];

  // Occupancy flags come from registered pointers only.
  assign sq_full  = (tail_q ^ head_q) == {1'b1, {IDXW{1'b0}}};
  assign sq_empty = (tail_q == head_q);
  assign sq_tail  = tail_q;

  assign disp_fire   = disp_valid && !sq_full && !mispred;
  assign exec_fire   = exec_valid && (state_q[exec_idx] == ST_ALLOC);
  assign retire_fire = retire_valid && (state_q[commit_idx] == ST_READY);
  assign drain_fire  = st_req_valid && st_req_ready;

  assign st_req_valid = (state_q[head_idx] == ST_COMMIT);
  assign st_req_addr  = {addr_q[head_idx], 2'b00};
  assign st_req_data  = data_q[head_idx];
  assign st_req_mask  = mask_q[head_idx];

  // Lane-align execute data; bytes outside the store's footprint are zeroed.
  always_comb begin
    case (exec_size)
      2'd0:    exec_mask = 4'b0001 << exec_addr[1:0];
      2'd1:    exec_mask = 4'b0011 << exec_addr[1:0];
      default: exec_mask = 4'b1111;
    endcase
    exec_shift = exec_data << {exec_addr[1:0], 3'b000};
    for (int b = 0; b < 4; b++) begin
      exec_lane_data[8*b +: 8] = exec_shift[8*b +: 8] & {8{exec_mask[b]}};
    end
  end

  always_comb begin
    head_d   = head_q + PW'(drain_fire);
    commit_d = commit_q + PW'(retire_fire);
    tail_d   = mispred ? rollback_tail : tail_q + PW'(disp_fire);
  end

  // Entry state update; squash is applied after execute so it wins on the same entry.
  always_comb begin
    state_d    = state_q;
    squash_cnt = tail_q - rollback_tail;
    if (drain_fire)  state_d[head_idx]   = ST_FREE;
    if (retire_fire) state_d[commit_idx] = ST_COMMIT;
    if (exec_fire)   state_d[exec_idx]   = ST_READY;
    for (int i = 0; i < SQ_SZ; i++) begin
      if (mispred && ({1'b0, IDXW'(i) - rollback_tail[IDXW-1:0]} < squash_cnt)) begin
        state_d[i] = ST_FREE;
      end
    end
    if (disp_fire) state_d[tail_idx] = ST_ALLOC;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= '0;
      for (int i = 0; i < SQ_SZ; i++) state_q[i] <= ST_FREE;
    end else begin
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && exec_fire) begin
      addr_q[exec_idx] <= exec_addr[31:2];
      data_q[exec_idx] <= exec_lane_data;
      mask_q[exec_idx] <= exec_mask;
    end
  end

  // Forwarding: walk oldest to youngest so younger matches overwrite older lanes.
  always_comb begin
    sq_load_data    = '0;
    sq_data_mask    = '0;
    sq_addr_unknown = 1'b0;
    fwd_idx         = '0;
    fwd_span        = load_sq_tail - head_q;
    for (int k = 0; k < SQ_SZ; k++) begin
      fwd_idx = head_idx + IDXW'(k);
      if (PW'(k) < fwd_span) begin
        if (state_q[fwd_idx] == ST_ALLOC) begin
          sq_addr_unknown = 1'b1;
        end else if ((state_q[fwd_idx] != ST_FREE) &&
                     (addr_q[fwd_idx] == load_req_addr[31:2])) begin
          for (int b = 0; b < 4; b++) begin
            if (mask_q[fwd_idx][b]) begin
              sq_load_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
              sq_data_mask[b]        = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
